serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; the legal range is 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin an addition, sampled on the rising clk edge.
REQ-005 The block SHALL have port a, input, WIDTH bits, first operand, sampled only on an accepted start.
REQ-006 The block SHALL have port b, input, WIDTH bits, second operand, sampled only on an accepted start.
REQ-007 The block SHALL have port cin, input, 1 bit, carry-in, sampled only on an accepted start.
REQ-008 The block SHALL have port busy, output, 1 bit, high while the serial addition is in progress.
REQ-009 The block SHALL have port done, output, 1 bit, a one-cycle pulse indicating that sum and cout are updated.
REQ-010 The block SHALL have port sum, output, WIDTH bits, registered result, held until the next completion.
REQ-011 The block SHALL have port cout, output, 1 bit, registered carry out of the MSB, held with sum.

Function
REQ-012 The block SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-013 In IDLE or DONE, start=1 at an edge SHALL be accepted: the edge loads a, b and cin into internal shift and carry registers, clears the bit counter, and moves the state to RUN.
REQ-014 In IDLE or DONE, start=0 SHALL move or keep the state at IDLE.
REQ-015 In RUN, each edge SHALL process one bit, LSB first, through a single full-adder cell: result bit = a0^b0^c, and the carry register is loaded with majority(a0, b0, c).
REQ-016 In RUN, each edge SHALL right-shift the operand registers and shift the result bit into the MSB of an internal result register.
REQ-017 RUN SHALL last exactly WIDTH edges; on the WIDTH-th edge, sum SHALL load the completed result, cout SHALL load the final carry, and the state SHALL move to DONE.
REQ-018 The latency SHALL be fixed: when start is accepted at edge 0, done SHALL be high in the cycle following edge WIDTH, for exactly one cycle.
REQ-019 busy SHALL equal (state==RUN) and SHALL be high for exactly WIDTH cycles per operation.
REQ-020 done SHALL equal (state==DONE).
REQ-021 start while in RUN SHALL be ignored; the operation in progress and its operands SHALL be unaffected.
REQ-022 Back-to-back operation: start accepted in the DONE cycle SHALL begin a new operation with no idle cycle in between; sum and cout SHALL keep the previous result until the new completion.
REQ-023 The arithmetic SHALL be modulo 2^WIDTH: {cout,sum} = a + b + cin exactly, and no other overflow indication is produced.
REQ-024 Changes on a, b or cin outside an accepted start edge SHALL have no effect on the block.

Reset
REQ-025 Assertion of rst_n=0 SHALL, asynchronously, force the state to IDLE and set busy=0, done=0, sum=0, cout=0, and the internal registers and counter to 0.
REQ-026 A reset mid-operation SHALL abandon that operation with no done pulse; the first start after release SHALL operate normally.
REQ-027 start SHALL be ignored while rst_n=0.

Verification (WIDTH=8)
REQ-028 The bench SHALL cover: a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0, with done exactly 9 cycles after the start edge and busy high for 8 cycles.
REQ-029 The bench SHALL cover: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
REQ-030 The bench SHALL cover: a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1; then a=0x5A, b=0x33, cin=1 with start held in the DONE cycle -> sum=0x8E, cout=0, with 0xFF/1 held until that completion.
REQ-031 The bench SHALL cover: start with a=0x0F, b=0x01, then start with a=0xAA, b=0xAA held during RUN -> the single result sum=0x10, cout=0 and no extra done pulse.
REQ-032 The bench SHALL cover: rst_n low during the third RUN cycle -> busy=0, done=0, sum=0x00, cout=0 immediately; a subsequent a=0x03, b=0x04, cin=0 -> sum=0x07.
REQ-033 The bench SHALL include a self-check of 200 random {a, b, cin} operations against a+b+cin.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder, one full-adder cell, WIDTH cycles per operation.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] ra, rb, res;
  logic [CW-1:0] cnt;
  logic c, s, maj, last;
  assign s    = ra[0] ^ rb[0] ^ c;
  assign maj  = (ra[0] & rb[0]) | (ra[0] & c) | (rb[0] & c);
  assign last = cnt == CW'(WIDTH - 1);
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    state_nx = IDLE;
    state_nx = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Operands are captured only on an accepted start; RUN shifts them out LSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra   <= '0;
      rb   <= '0;
      res  <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
    end else if (state != RUN) begin
      if (start) begin
        ra  <= a;
        rb  <= b;
        c   <= cin;
        cnt <= '0;
      end
    end else begin
      ra  <= ra >> 1;
      rb  <= rb >> 1;
      c   <= maj;
      res <= {s, res[WIDTH-1:1]};
      cnt <= cnt + 1'b1;
      if (last) begin
        sum  <= {s, res[WIDTH-1:1]};
        cout <= maj;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random self-checking bench for serial_adder (WIDTH=8).
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout;
  logic [7:0] sum;
  int checks = 0, errors = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  // Called at posedge+1; returns at posedge+1 of the DONE cycle (or after a 20-edge budget).
  task automatic do_op(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                       output int lat, output int bc, output logic held);
    logic [7:0] s0;
    logic c0;
    s0 = sum;
    c0 = cout;
    held = 1'b1;
    a = va; b = vb; cin = vc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    bc = 0;
    while (!done && lat < 20) begin
      if (busy) bc++;
      if (sum !== s0 || cout !== c0) held = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    start = 1'b1; a = 8'h11; b = 8'h22;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({busy, done, cout, sum} !== 11'h0) begin errors++; $display("FAIL reset_state: got %h expected %h", {busy, done, cout, sum}, 11'h0); end
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_release_idle: got %b expected 00", {busy, done}); end
  endtask

  task automatic test_zero;
    int lat, bc; logic held;
    do_op(8'h00, 8'h00, 1'b0, lat, bc, held);
    checks++; if (lat !== 8) begin errors++; $display("FAIL zero_latency: got %0d expected 8", lat); end
    checks++; if (bc !== 8) begin errors++; $display("FAIL zero_busy_cycles: got %0d expected 8", bc); end
    checks++; if ({cout, sum} !== 9'h000) begin errors++; $display("FAIL zero_result: got %h expected 000", {cout, sum}); end
    @(posedge clk); #1;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL zero_done_width: got %b expected 00", {busy, done}); end
  endtask

  task automatic test_carry;
    int lat, bc; logic held;
    do_op(8'hFF, 8'h01, 1'b0, lat, bc, held);
    checks++; if ({cout, sum} !== 9'h100) begin errors++; $display("FAIL carry_result: got %h expected 100", {cout, sum}); end
  endtask

  task automatic test_back_to_back;
    int lat, bc; logic held;
    do_op(8'hFF, 8'hFF, 1'b1, lat, bc, held);
    checks++; if ({cout, sum} !== 9'h1FF) begin errors++; $display("FAIL b2b_first: got %h expected 1ff", {cout, sum}); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_in_done: got %b expected 1", done); end
    do_op(8'h5A, 8'h33, 1'b1, lat, bc, held);
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL b2b_hold: got %b expected 1", held); end
    checks++; if (lat !== 8 || bc !== 8) begin errors++; $display("FAIL b2b_timing: got lat %0d busy %0d expected 8 8", lat, bc); end
    checks++; if ({cout, sum} !== 9'h08E) begin errors++; $display("FAIL b2b_second: got %h expected 08e", {cout, sum}); end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start;
    int lat, pulses;
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 8'hAA; b = 8'hAA; cin = 1'b1;
    lat = 0;
    while (!done && lat < 20) begin
      start = (lat < 6);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    checks++; if (lat !== 8) begin errors++; $display("FAIL ignore_latency: got %0d expected 8", lat); end
    checks++; if ({cout, sum} !== 9'h010) begin errors++; $display("FAIL ignore_result: got %h expected 010", {cout, sum}); end
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL ignore_extra_done: got %0d expected 0", pulses); end
  endtask

  task automatic test_reset_mid;
    int lat, bc, pulses; logic held;
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, cout, sum} !== 11'h0) begin errors++; $display("FAIL midreset_clear: got %h expected 000", {busy, done, cout, sum}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midreset_no_done: got %0d expected 0", pulses); end
    do_op(8'h03, 8'h04, 1'b0, lat, bc, held);
    checks++; if ({cout, sum} !== 9'h007 || lat !== 8) begin errors++; $display("FAIL midreset_after: got %h lat %0d expected 007 lat 8", {cout, sum}, lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    int lat, bc; logic held;
    logic [7:0] va, vb; logic vc; logic [8:0] exp;
    for (int i = 0; i < 200; i++) begin
      va = 8'($urandom); vb = 8'($urandom); vc = 1'($urandom);
      exp = {1'b0, va} + {1'b0, vb} + {8'h00, vc};
      do_op(va, vb, vc, lat, bc, held);
      checks++; if ({cout, sum} !== exp || lat !== 8) begin errors++; $display("FAIL random_%0d: got %h lat %0d expected %h lat 8 (a=%h b=%h cin=%b)", i, {cout, sum}, lat, exp, va, vb, vc); end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_carry();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
